// File: rtl/smi_mem_lib_test_pkg.sv
// smi_mem_lib_test_pkg: shared definitions for the memory-library read test
// sequencer: sequencer state encoding and datapath field widths.
package smi_mem_lib_test_pkg;

  localparam int SMI_ADDR_WIDTH = 64;
  localparam int SMI_DATA_WIDTH = 64;
  localparam int SMI_LEN_WIDTH  = 32;
  localparam int SMI_OPTS_WIDTH = 8;

  typedef enum logic [1:0] {
    SeqIdle     = 2'd0,
    SeqIssue    = 2'd1,
    SeqWaitDone = 2'd2,
    SeqReport   = 2'd3
  } seqState_e;

endpackage

// File: rtl/smi_sat_counter.sv
// smi_sat_counter: up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over an increment in the same cycle.
module smi_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  // count up on incr, hold once all-ones is reached
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/smi_mem_lib_read_test_sequencer.sv
// smi_mem_lib_read_test_sequencer: accepts one run request and hands the
// checker a sequence of bursts, stepping address and data seed by their
// strides after each completed burst, then reports the number of failed
// bursts. All channels use valid/stop: transfer when valid=1 and stop=0.
// Optional build macro SMI_SEQ_ABORT_ON_FAIL_EN: the first failed burst ends
// the run and goes straight to the report.
//
// state       | meaning
// SeqIdle     | waiting for a run request, runStop low
// SeqIssue    | presenting burst parameters to the checker
// SeqWaitDone | waiting for the checker to finish the current burst
// SeqReport   | presenting the result until it is taken
module smi_mem_lib_read_test_sequencer
  import smi_mem_lib_test_pkg::*;
#(
  parameter int FAIL_COUNT_WIDTH  = 16,
  parameter int BURST_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstN,

  input  logic                         runValid,
  input  logic [SMI_ADDR_WIDTH-1:0]    runBaseAddr,
  input  logic [SMI_ADDR_WIDTH-1:0]    runAddrStride,
  input  logic [SMI_LEN_WIDTH-1:0]     runBurstLen,
  input  logic [SMI_OPTS_WIDTH-1:0]    runBurstOpts,
  input  logic [BURST_COUNT_WIDTH-1:0] runBurstCount,
  input  logic [SMI_DATA_WIDTH-1:0]    runDataInit,
  input  logic [SMI_DATA_WIDTH-1:0]    runDataIncr,
  input  logic [SMI_DATA_WIDTH-1:0]    runDataStride,
  output logic                         runStop,

  output logic                         testParamsValid,
  output logic [SMI_ADDR_WIDTH-1:0]    testParamBurstAddr,
  output logic [SMI_LEN_WIDTH-1:0]     testParamBurstLen,
  output logic [SMI_OPTS_WIDTH-1:0]    testParamBurstOpts,
  output logic [SMI_DATA_WIDTH-1:0]    testParamDataInit,
  output logic [SMI_DATA_WIDTH-1:0]    testParamDataIncr,
  input  logic                         testParamsStop,

  input  logic                         testDoneValid,
  input  logic                         testDoneStatusOk,
  output logic                         testDoneStop,

  output logic                         resultValid,
  output logic                         resultStatusOk,
  output logic [FAIL_COUNT_WIDTH-1:0]  resultFailCount,
  input  logic                         resultStop
);

  seqState_e                     state;
  logic [BURST_COUNT_WIDTH-1:0]  remainCount;
  logic [FAIL_COUNT_WIDTH-1:0]   failCount;

  logic [SMI_ADDR_WIDTH-1:0]     curAddr;
  logic [SMI_ADDR_WIDTH-1:0]     addrStride;
  logic [SMI_LEN_WIDTH-1:0]      burstLen;
  logic [SMI_OPTS_WIDTH-1:0]     burstOpts;
  logic [SMI_DATA_WIDTH-1:0]     curData;
  logic [SMI_DATA_WIDTH-1:0]     dataIncr;
  logic [SMI_DATA_WIDTH-1:0]     dataStride;

  logic runFire;
  logic paramFire;
  logic doneFire;
  logic resultFire;
  logic lastBurst;

  // runStop and testDoneStop are only low in Idle and WaitDone respectively,
  // so these also qualify each transfer with the owning state.
  assign runFire    = runValid && !runStop && (state == SeqIdle);
  assign paramFire  = testParamsValid && !testParamsStop;
  assign doneFire   = testDoneValid && !testDoneStop && (state == SeqWaitDone);
  assign resultFire = resultValid && !resultStop;

  // decide whether the burst finishing now is the last one of the run
  always_comb begin
    lastBurst = (remainCount <= BURST_COUNT_WIDTH'(1));
`ifdef SMI_SEQ_ABORT_ON_FAIL_EN
    if (!testDoneStatusOk) begin
      lastBurst = 1'b1;
    end
`endif
  end

  // sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state           <= SeqIdle;
      remainCount     <= '0;
      runStop         <= 1'b0;
      testParamsValid <= 1'b0;
      testDoneStop    <= 1'b1;
      resultValid     <= 1'b0;
    end else begin
      case (state)
        SeqIdle: begin
          if (runFire) begin
            remainCount <= runBurstCount;
            runStop     <= 1'b1;
            if (runBurstCount == '0) begin
              state       <= SeqReport;
              resultValid <= 1'b1;
            end else begin
              state           <= SeqIssue;
              testParamsValid <= 1'b1;
            end
          end
        end
        SeqIssue: begin
          if (paramFire) begin
            state           <= SeqWaitDone;
            testParamsValid <= 1'b0;
            testDoneStop    <= 1'b0;
          end
        end
        SeqWaitDone: begin
          if (doneFire) begin
            remainCount  <= remainCount - BURST_COUNT_WIDTH'(1);
            testDoneStop <= 1'b1;
            if (lastBurst) begin
              state       <= SeqReport;
              resultValid <= 1'b1;
            end else begin
              state           <= SeqIssue;
              testParamsValid <= 1'b1;
            end
          end
        end
        SeqReport: begin
          if (resultFire) begin
            state       <= SeqIdle;
            resultValid <= 1'b0;
            runStop     <= 1'b0;
          end
        end
        default: begin
          state           <= SeqIdle;
          runStop         <= 1'b0;
          testParamsValid <= 1'b0;
          testDoneStop    <= 1'b1;
          resultValid     <= 1'b0;
        end
      endcase
    end
  end

  // run parameters latched on accept; address and seed step after each burst
  always_ff @(posedge clk) begin
    if (runFire) begin
      curAddr    <= runBaseAddr;
      addrStride <= runAddrStride;
      burstLen   <= runBurstLen;
      burstOpts  <= runBurstOpts;
      curData    <= runDataInit;
      dataIncr   <= runDataIncr;
      dataStride <= runDataStride;
    end else if (doneFire) begin
      curAddr <= curAddr + addrStride;
      curData <= curData + dataStride;
    end
  end

  smi_sat_counter #(
    .WIDTH(FAIL_COUNT_WIDTH)
  ) uFailCounter (
    .clk  (clk),
    .rstN (rstN),
    .clear(runFire),
    .incr (doneFire && !testDoneStatusOk),
    .count(failCount)
  );

  assign testParamBurstAddr = curAddr;
  assign testParamBurstLen  = burstLen;
  assign testParamBurstOpts = burstOpts;
  assign testParamDataInit  = curData;
  assign testParamDataIncr  = dataIncr;

  assign resultFailCount = failCount;
  assign resultStatusOk  = (failCount == '0);

endmodule

// File: tb/tb_smi_mem_lib_read_test_sequencer.sv
// tb_smi_mem_lib_read_test_sequencer: directed runs against a transaction-level
// model of the sequencer, checked every cycle on the falling clock edge.
module tb_smi_mem_lib_read_test_sequencer;

  localparam int FCW  = 2;
  localparam int BCW  = 16;
  localparam int FMAX = (1 << FCW) - 1;

  logic           clk;
  logic           rstN;
  logic           runValid;
  logic [63:0]    runBaseAddr, runAddrStride, runDataInit, runDataIncr, runDataStride;
  logic [31:0]    runBurstLen;
  logic [7:0]     runBurstOpts;
  logic [BCW-1:0] runBurstCount;
  logic           runStop;
  logic           testParamsValid;
  logic [63:0]    testParamBurstAddr, testParamDataInit, testParamDataIncr;
  logic [31:0]    testParamBurstLen;
  logic [7:0]     testParamBurstOpts;
  logic           testParamsStop;
  logic           testDoneValid, testDoneStatusOk, testDoneStop;
  logic           resultValid, resultStatusOk, resultStop;
  logic [FCW-1:0] resultFailCount;

  smi_mem_lib_read_test_sequencer #(
    .FAIL_COUNT_WIDTH (FCW),
    .BURST_COUNT_WIDTH(BCW)
  ) dut (
    .clk               (clk),
    .rstN              (rstN),
    .runValid          (runValid),
    .runBaseAddr       (runBaseAddr),
    .runAddrStride     (runAddrStride),
    .runBurstLen       (runBurstLen),
    .runBurstOpts      (runBurstOpts),
    .runBurstCount     (runBurstCount),
    .runDataInit       (runDataInit),
    .runDataIncr       (runDataIncr),
    .runDataStride     (runDataStride),
    .runStop           (runStop),
    .testParamsValid   (testParamsValid),
    .testParamBurstAddr(testParamBurstAddr),
    .testParamBurstLen (testParamBurstLen),
    .testParamBurstOpts(testParamBurstOpts),
    .testParamDataInit (testParamDataInit),
    .testParamDataIncr (testParamDataIncr),
    .testParamsStop    (testParamsStop),
    .testDoneValid     (testDoneValid),
    .testDoneStatusOk  (testDoneStatusOk),
    .testDoneStop      (testDoneStop),
    .resultValid       (resultValid),
    .resultStatusOk    (resultStatusOk),
    .resultFailCount   (resultFailCount),
    .resultStop        (resultStop)
  );

  int total = 0;
  int bad   = 0;

  // model state
  bit          mActive = 0;
  logic [63:0] mBase, mStride, mDInit, mDIncr, mDStride;
  logic [31:0] mLen;
  logic [7:0]  mOpts;
  int          mNExp, mIssued, mDone, mFails;
  logic [31:0] failMaskG = '0;

  // driver observations
  logic [63:0] addrLog [0:15];
  int          nIssued;
  logic        lastStatus;
  logic [FCW-1:0] lastFail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // model: compare outputs on every falling edge, then account for transfers
  initial begin
    bit expTpv, expRv, expTds;
    int sat, n;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        chk("rst_runStop", 64'(runStop), 64'(0));
        chk("rst_tpv", 64'(testParamsValid), 64'(0));
        chk("rst_rv", 64'(resultValid), 64'(0));
        chk("rst_tds", 64'(testDoneStop), 64'(1));
        mActive = 0;
      end else begin
        expTds = !(mActive && (mIssued > mDone));
        expTpv = mActive && (mIssued == mDone) && (mIssued < mNExp);
        expRv  = mActive && (mIssued == mNExp) && (mDone == mNExp);
        chk("runStop", 64'(runStop), 64'(mActive));
        chk("testDoneStop", 64'(testDoneStop), 64'(expTds));
        chk("testParamsValid", 64'(testParamsValid), 64'(expTpv));
        chk("resultValid", 64'(resultValid), 64'(expRv));
        if (expTpv && testParamsValid) begin
          chk("pAddr", testParamBurstAddr, mBase + 64'(mIssued) * mStride);
          chk("pDataInit", testParamDataInit, mDInit + 64'(mIssued) * mDStride);
          chk("pLen", 64'(testParamBurstLen), 64'(mLen));
          chk("pOpts", 64'(testParamBurstOpts), 64'(mOpts));
          chk("pIncr", testParamDataIncr, mDIncr);
        end
        if (expRv && resultValid) begin
          sat = (mFails > FMAX) ? FMAX : mFails;
          chk("rFailCount", 64'(resultFailCount), 64'(sat));
          chk("rStatusOk", 64'(resultStatusOk), 64'(sat == 0));
        end
        if (!mActive) begin
          if (runValid && !runStop) begin
            mActive  = 1;
            mBase    = runBaseAddr;
            mStride  = runAddrStride;
            mLen     = runBurstLen;
            mOpts    = runBurstOpts;
            mDInit   = runDataInit;
            mDIncr   = runDataIncr;
            mDStride = runDataStride;
            mIssued  = 0;
            mDone    = 0;
            mFails   = 0;
            n        = int'(runBurstCount);
            mNExp    = n;
`ifdef SMI_SEQ_ABORT_ON_FAIL_EN
            for (int i = n - 1; i >= 0; i--)
              if (i < 32 && failMaskG[i]) mNExp = i + 1;
`endif
          end
        end else begin
          if (testParamsValid && !testParamsStop) mIssued++;
          if (testDoneValid && !testDoneStop) begin
            mDone++;
            if (!testDoneStatusOk) mFails++;
          end
          if (resultValid && !resultStop) mActive = 0;
        end
      end
    end
  end

  // one complete run acting as both requester and checker
  task automatic runTest(input logic [63:0] base, input logic [63:0] stride, input int count,
                         input logic [31:0] failMask, input int paramStall, input int resultStall,
                         input bit earlyDone);
    int guard, g2, b;
    bit finished;
    nIssued = 0;
    b = 0;
    @(posedge clk); #1;
    failMaskG      = failMask;
    runValid       = 1'b1;
    runBaseAddr    = base;
    runAddrStride  = stride;
    runBurstLen    = 32'(64 + count);
    runBurstOpts   = 8'(32'h5A ^ count);
    runBurstCount  = BCW'(count);
    runDataInit    = 64'hA5A5_0000_0000_0000 + base;
    runDataIncr    = 64'h1 + 64'(count);
    runDataStride  = stride << 1;
    testParamsStop = (paramStall > 0);
    resultStop     = (resultStall > 0);
    guard = 0;
    @(negedge clk);
    while (runStop && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (runStop) begin
      timeout("run_accept");
      runValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    runValid      = 1'b0;
    runBaseAddr   = '1;
    runAddrStride = '1;
    runBurstLen   = '1;
    runBurstOpts  = '1;
    runDataInit   = '1;
    runDataIncr   = '1;
    runDataStride = '1;
    finished = 0;
    guard = 0;
    while (!finished && guard < 200) begin
      @(negedge clk);
      guard++;
      if (resultValid) begin
        if (resultStop) begin
          repeat (resultStall) @(posedge clk);
          #1 resultStop = 1'b0;
          @(negedge clk);
        end
        lastStatus = resultStatusOk;
        lastFail   = resultFailCount;
        @(posedge clk); #1;
        finished = 1;
      end else if (testParamsValid) begin
        if (testParamsStop) begin
          if (earlyDone) begin
            testDoneValid    = 1'b1;
            testDoneStatusOk = 1'b0;
          end
          repeat (paramStall) @(posedge clk);
          #1;
          testDoneValid    = 1'b0;
          testDoneStatusOk = 1'b1;
          testParamsStop   = 1'b0;
          @(negedge clk);
        end
        if (nIssued < 16) addrLog[nIssued] = testParamBurstAddr;
        nIssued++;
        @(posedge clk); #1;
        testDoneValid    = 1'b1;
        testDoneStatusOk = (b < 32) ? !failMask[b] : 1'b1;
        b++;
        g2 = 0;
        @(negedge clk);
        while (testDoneStop && g2 < 20) begin
          @(negedge clk);
          g2++;
        end
        if (testDoneStop) timeout("done_accept");
        @(posedge clk); #1;
        testDoneValid    = 1'b0;
        testDoneStatusOk = 1'b1;
      end
    end
    if (!finished) timeout("run_complete");
  endtask

  initial begin
    rstN = 1'b0;
    runValid = 1'b0;
    runBaseAddr = '0; runAddrStride = '0; runBurstLen = '0; runBurstOpts = '0;
    runBurstCount = '0; runDataInit = '0; runDataIncr = '0; runDataStride = '0;
    testParamsStop = 1'b0;
    testDoneValid = 1'b0;
    testDoneStatusOk = 1'b1;
    resultStop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // three passing bursts
    runTest(64'h1000, 64'h100, 3, 32'h0, 0, 0, 0);
    chk("t1_issued", 64'(nIssued), 64'd3);
    chk("t1_addr0", addrLog[0], 64'h1000);
    chk("t1_addr1", addrLog[1], 64'h1100);
    chk("t1_addr2", addrLog[2], 64'h1200);
    chk("t1_status", 64'(lastStatus), 64'd1);
    chk("t1_fail", 64'(lastFail), 64'd0);

    // second of four bursts fails
    runTest(64'h2000, 64'h40, 4, 32'h2, 0, 0, 0);
`ifdef SMI_SEQ_ABORT_ON_FAIL_EN
    chk("t2_issued", 64'(nIssued), 64'd2);
`else
    chk("t2_issued", 64'(nIssued), 64'd4);
    chk("t2_addr3", addrLog[3], 64'h20C0);
`endif
    chk("t2_fail", 64'(lastFail), 64'd1);
    chk("t2_status", 64'(lastStatus), 64'd0);

    // zero bursts goes straight to the report
    runTest(64'h5000, 64'h10, 0, 32'h0, 0, 0, 0);
    chk("t3_issued", 64'(nIssued), 64'd0);
    chk("t3_status", 64'(lastStatus), 64'd1);
    chk("t3_fail", 64'(lastFail), 64'd0);

    // stalled parameters/result and an early done that must be ignored
    runTest(64'h6000, 64'h8, 2, 32'h0, 5, 3, 1);
    chk("t4_issued", 64'(nIssued), 64'd2);
    chk("t4_addr1", addrLog[1], 64'h6008);
    chk("t4_status", 64'(lastStatus), 64'd1);

    // address wraps through zero
    runTest(64'hFFFF_FFFF_FFFF_FF00, 64'h100, 2, 32'h0, 0, 0, 0);
    chk("t5_addr0", addrLog[0], 64'hFFFF_FFFF_FFFF_FF00);
    chk("t5_addr1", addrLog[1], 64'h0);

    // fail counter saturation
    runTest(64'h7000, 64'h20, 5, 32'h1F, 0, 0, 0);
`ifdef SMI_SEQ_ABORT_ON_FAIL_EN
    chk("t6_fail", 64'(lastFail), 64'd1);
`else
    chk("t6_fail", 64'(lastFail), 64'd3);
`endif
    chk("t6_status", 64'(lastStatus), 64'd0);

    // reset in the middle of a burst
    @(posedge clk); #1;
    failMaskG     = '0;
    runValid      = 1'b1;
    runBaseAddr   = 64'h3000;
    runAddrStride = 64'h10;
    runBurstLen   = 32'h10;
    runBurstOpts  = 8'h3;
    runBurstCount = BCW'(3);
    runDataInit   = 64'h55;
    runDataIncr   = 64'h2;
    runDataStride = 64'h4;
    @(posedge clk); #1;
    runValid = 1'b0;
    @(posedge clk); #1;
    chk("t7_in_wait", 64'(testDoneStop), 64'd0);
    #2 rstN = 1'b0;
    #1;
    chk("t7_rst_runStop", 64'(runStop), 64'd0);
    chk("t7_rst_tds", 64'(testDoneStop), 64'd1);
    chk("t7_rst_tpv", 64'(testParamsValid), 64'd0);
    repeat (2) @(negedge clk);
    #2 rstN = 1'b1;
    runTest(64'h4000, 64'h20, 2, 32'h0, 0, 0, 0);
    chk("t7_issued", 64'(nIssued), 64'd2);
    chk("t7_addr1", addrLog[1], 64'h4020);
    chk("t7_status", 64'(lastStatus), 64'd1);
    chk("t7_fail", 64'(lastFail), 64'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/smi_mem_lib_read_test_sequencer.md
SMI_MEM_LIB_READ_TEST_SEQUENCER -- requirements
Module: smi_mem_lib_read_test_sequencer

Interface
REQ-001 SHALL have parameter FAIL_COUNT_WIDTH, default 16, giving the width of the failure counter.
REQ-002 SHALL have parameter BURST_COUNT_WIDTH, default 16, giving the width of the burst count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have run request inputs: runValid 1; runBaseAddr 64; runAddrStride 64; runBurstLen 32; runBurstOpts 8; runBurstCount BURST_COUNT_WIDTH; runDataInit 64; runDataIncr 64; runDataStride 64.
REQ-006 SHALL have port runStop, output, 1 bit: the run request backpressure.
REQ-007 SHALL have checker parameter outputs: testParamsValid 1; testParamBurstAddr 64; testParamBurstLen 32; testParamBurstOpts 8; testParamDataInit 64; testParamDataIncr 64.
REQ-008 SHALL have port testParamsStop, input, 1 bit: checker parameter backpressure.
REQ-009 SHALL have checker done ports: testDoneValid input 1; testDoneStatusOk input 1; testDoneStop output 1.
REQ-010 SHALL have result outputs resultValid 1, resultStatusOk 1, resultFailCount FAIL_COUNT_WIDTH, and result input resultStop 1.
REQ-011 SHALL use one handshake rule on every channel: a transfer occurs on a rising edge where valid=1 and stop=0.

Function
REQ-012 SHALL implement states Idle, Issue, WaitDone and Report.
REQ-013 Idle SHALL drive runStop=0 and latch all run inputs on a run transfer.
REQ-014 On a run transfer, Idle SHALL go to Report if runBurstCount=0, otherwise to Issue.
REQ-015 In all states other than Idle, runStop SHALL be 1.
REQ-016 Issue SHALL drive testParamsValid=1, burst address = current address, data init = current data init, length/opts/incr = latched values.
REQ-017 Issue SHALL go to WaitDone on a parameter transfer.
REQ-018 WaitDone SHALL drive testDoneStop=0; in every other state testDoneStop SHALL be 1.
REQ-019 On a done transfer, WaitDone SHALL decrement the remaining count, add runAddrStride to the address and add runDataStride to the data init.
REQ-020 On a done transfer with testDoneStatusOk=0, WaitDone SHALL increment the fail counter, saturating at all-ones.
REQ-021 After a done transfer, WaitDone SHALL go to Issue if the remaining count before decrement was greater than 1, otherwise to Report.
REQ-022 All address and data arithmetic SHALL be 64-bit modulo 2^64, wrapping silently.
REQ-023 Report SHALL drive resultValid=1, resultFailCount = counter, and resultStatusOk=1 only if the counter is 0.
REQ-024 Report SHALL go to Idle on a result transfer; the counter is cleared on the next run accept.
REQ-025 Latency SHALL be one cycle from run accept to testParamsValid, and one cycle from the final done transfer to resultValid.
REQ-026 Back-to-back bursts SHALL issue with testParamsValid asserted in the cycle after a done transfer.
REQ-027 A done transfer presented outside WaitDone SHALL be ignored, and testDoneValid SHALL be ignored while testDoneStop=1.

Reset
REQ-028 Asserting rstN low SHALL immediately force state Idle.
REQ-029 During reset: testParamsValid=0, resultValid=0, testDoneStop=1, runStop=0.
REQ-030 During reset the fail counter and remaining count SHALL be cleared.
REQ-031 Reset mid-burst SHALL abandon the run; the checker is expected to be reset alongside.
REQ-032 Datapath registers (address, data, latched parameters) SHALL be non-resettable.

Configuration
REQ-033 Macro SMI_SEQ_ABORT_ON_FAIL_EN SHALL control the response to a failed burst.
REQ-034 With SMI_SEQ_ABORT_ON_FAIL_EN defined, a done transfer with testDoneStatusOk=0 SHALL go directly to Report, regardless of the remaining count.
REQ-035 Without SMI_SEQ_ABORT_ON_FAIL_EN, all bursts SHALL run to completion.

Structure
REQ-036 Shared package smi_mem_lib_test_pkg SHALL hold the sequencer state encoding and the 64/32/8-bit address, length and opts width constants.
REQ-037 The saturating fail counter SHALL be a sub-module, smi_sat_counter, parameterised by width.

Verification
REQ-038 Run base 0x1000, stride 0x100, count 3, all pass -> bursts issued at 0x1000/0x1100/0x1200, then resultStatusOk=1, failCount=0.
REQ-039 Count 4, second burst fails, macro undefined -> 4 bursts issued, failCount=1, statusOk=0; with macro defined -> 2 bursts issued, failCount=1.
REQ-040 runBurstCount=0 -> no testParamsValid; resultValid one cycle after the run accept, statusOk=1.
REQ-041 testParamsStop held 5 cycles and resultStop held 3 cycles -> parameters and result held stable, no duplicate issue.
REQ-042 runBaseAddr 0xFFFF_FFFF_FFFF_FF00, stride 0x100, count 2 -> second address 0x0.
REQ-043 FAIL_COUNT_WIDTH=2, 5 failing bursts -> failCount saturates at 3.
REQ-044 rstN pulsed low in WaitDone -> Idle immediately, runStop=0, and a new run completes correctly.
